// File: rtl/sram_img_reader.sv
// sram_img_reader: reads a burst of `len` words from a synchronous SRAM, starting at `base`,
// and streams them out over a valid/ready interface.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   start, base, len  one-cycle burst request (ignored unless idle); len = 0 is an empty burst
//   busy, done        busy from the cycle after an accepted start; done is a one-cycle pulse
//   sram_csn/wen/a    SRAM control (read-only: wen tied low), one read per csn-low cycle
//   sram_dout         SRAM read data, valid the cycle after a csn-low cycle
//   m_valid/ready     output stream handshake
//   m_data, m_last    output word and end-of-burst marker
//
// Buffering: a read returns its word in the cycle after issue. That word is visible on the
// stream straight from sram_dout in that same cycle (fall-through). If it is not taken, it is
// written into a 2-entry store at the end of the cycle. Reads are only issued while
// stored + inflight - pop < 2, so every returning word is guaranteed a slot.
module sram_img_reader #(
  parameter int unsigned AW = 19,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          sram_csn,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  input  logic [DW-1:0] sram_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rem_q, rem_d;        // reads still to be issued
  logic          inflight_q;          // a read was issued last cycle
  logic          inflight_last_q;     // ... and it was the final word of the burst
  logic          done_q, done_d;

  // Store entries carry {last, data}.
  logic [DW:0]   store_q [2];
  logic [1:0]    stored_q, stored_d;
  logic          wr_ptr_q, rd_ptr_q;

  logic          accept;
  logic          pop;
  logic          issue;
  logic          push_store;
  logic          pop_store;
  logic [1:0]    occ;
  logic [DW:0]   head;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    head       = '0;

    // Visible head: oldest stored word, else the word returning from SRAM this cycle.
    if (stored_q != 2'd0) begin
      head = store_q[rd_ptr_q];
    end else if (inflight_q) begin
      head = {inflight_last_q, sram_dout};
    end

    accept     = (state_q == StIdle) && start && !done_q;
    pop        = m_valid && m_ready;
    occ        = stored_q + {1'b0, inflight_q} - {1'b0, pop};
    issue      = (state_q == StRun) && (rem_q != '0) && (occ < 2'd2);

    // A returning word that is consumed in its own cycle never enters the store.
    push_store = inflight_q && !(pop && (stored_q == 2'd0));
    pop_store  = pop && (stored_q != 2'd0);
    stored_d   = stored_q + {1'b0, push_store} - {1'b0, pop_store};

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = base;
          rem_d   = len;
          state_d = (len != '0) ? StRun : StDrain;
        end
      end
      StRun: begin
        if (issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - AW'(1);
          if (rem_q == AW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // No reads are issued here, so inflight clears next cycle; finish once nothing remains.
        if (stored_d == 2'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      stored_q        <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      store_q[0]      <= '0;
      store_q[1]      <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == AW'(1));
      done_q          <= done_d;
      stored_q        <= stored_d;
      if (push_store) begin
        store_q[wr_ptr_q] <= {inflight_last_q, sram_dout};
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_store) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign sram_csn = ~issue;
  assign sram_wen = 1'b0;
  assign sram_a   = addr_q;
  assign m_valid  = (stored_q != 2'd0) || inflight_q;
  assign m_data   = head[DW-1:0];
  assign m_last   = head[DW];

endmodule

// File: tb/tb_sram_img_reader.sv
// Bench for sram_img_reader: directed bursts; expected addresses and words are queued when a
// burst is set up and a negedge monitor pops and compares them as the DUT presents them.
module tb_sram_img_reader;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;
  logic          sram_csn;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  sram_img_reader #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .sram_csn  (sram_csn),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_dout (sram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents as a fixed function of address.
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC35A ^ {13'd0, a[18:16]};
  endfunction

  // Synchronous SRAM: output registered on a csn-low edge, held otherwise.
  always @(posedge clk) begin
    if (!sram_csn) sram_dout <= mem_val(sram_a);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard queues.
  logic [AW-1:0] exp_a [$];
  logic [DW-1:0] exp_d [$];
  bit            exp_l [$];

  // Per-burst markers, written by the monitor.
  int cyc = 0;
  int t0;
  int t_first_issue, t_first_valid, t_last;
  int n_burst_reads, n_words, n_done;
  int n_issued, n_popped;
  bit rand_mode = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push_word(input logic [AW-1:0] a, input bit last);
    exp_a.push_back(a);
    exp_d.push_back(mem_val(a));
    exp_l.push_back(last);
  endtask

  task automatic push_burst(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) push_word(b + AW'(i), i == n - 1);
  endtask

  task automatic clr_marks();
    t_first_issue = -1;
    t_first_valid = -1;
    t_last        = -1;
    n_burst_reads = 0;
    n_words       = 0;
  endtask

  // Start is high for exactly cycle t0.
  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] n);
    clr_marks();
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = b;
    len   = n;
    t0    = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget, output int td);
    bit found;
    found = 0;
    td    = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        td    = cyc;
      end
    end
    chk("done_seen", found, 1);
    chk("busy_low_at_done", busy, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_csn", sram_csn, 1);
    chk("rst_wen", sram_wen, 0);
    chk("rst_a", sram_a, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
  endtask

  // Monitor: address order, read throttling, word order/content, stall stability.
  initial begin
    bit            stall_prev;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            occ;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_prev = 0;
      end else begin
        if (!sram_csn) begin
          if (exp_a.size() == 0) chk("unexpected_read", 1, 0);
          else chk("sram_a", sram_a, exp_a.pop_front());
          occ = n_issued - n_popped - int'(m_valid && m_ready);
          chk("issue_occupancy_lt2", occ < 2, 1);
          if (t_first_issue < 0) t_first_issue = cyc;
          n_burst_reads++;
          n_issued++;
        end
        if (m_valid) begin
          if (t_first_valid < 0) t_first_valid = cyc;
          if (stall_prev) begin
            chk("stall_data_stable", m_data, prev_data);
            chk("stall_last_stable", m_last, prev_last);
          end
          if (m_ready) begin
            if (exp_d.size() == 0) chk("extra_word", 1, 0);
            else begin
              chk("m_data", m_data, exp_d.pop_front());
              chk("m_last", m_last, exp_l.pop_front());
            end
            if (m_last) t_last = cyc;
            n_words++;
            n_popped++;
          end
        end
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (done) n_done++;
      end
    end
  end

  // Random backpressure driver.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int td;
    int done_before;
    rstn    = 1'b0;
    start   = 1'b0;
    base    = '0;
    len     = '0;
    m_ready = 1'b1;
    n_done  = 0;
    n_issued = 0;
    n_popped = 0;
    clr_marks();
    #1;
    chk_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Basic burst with exact latency.
    push_word(19'h00010, 0);
    push_word(19'h00011, 0);
    push_word(19'h00012, 0);
    push_word(19'h00013, 1);
    launch(19'h00010, 19'd4);
    wait_done(40, td);
    chk("first_issue_rel", t_first_issue - t0, 1);
    chk("first_valid_rel", t_first_valid - t0, 2);
    chk("last_rel", t_last - t0, 5);
    chk("done_rel", td - t0, 6);
    chk("reads_len4", n_burst_reads, 4);
    chk("words_len4", n_words, 4);

    // Address wrap at the top of the space.
    push_word(19'h7FFFE, 0);
    push_word(19'h7FFFF, 0);
    push_word(19'h00000, 0);
    push_word(19'h00001, 1);
    launch(19'h7FFFE, 19'd4);
    wait_done(40, td);
    chk("words_wrap", n_words, 4);
    chk("wrap_queue_empty", exp_a.size(), 0);

    // Random backpressure.
    push_burst(19'h02000, 8);
    rand_mode = 1;
    launch(19'h02000, 19'd8);
    wait_done(300, td);
    rand_mode = 0;
    m_ready   = 1'b1;
    chk("words_random", n_words, 8);
    chk("reads_random", n_burst_reads, 8);
    chk("random_queue_empty", exp_d.size(), 0);

    // Empty burst.
    done_before = n_done;
    launch(19'h00500, 19'd0);
    wait_done(20, td);
    chk("len0_reads", n_burst_reads, 0);
    chk("len0_no_valid", t_first_valid < 0, 1);
    chk("len0_done_rel", td - t0, 2);
    @(negedge clk);
    chk("len0_single_done", n_done - done_before, 1);

    // Start while busy and start during the done cycle are both ignored.
    done_before = n_done;
    push_burst(19'h00100, 3);
    launch(19'h00100, 19'd3);
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = 19'h00200;
    len   = 19'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40, td);
    start = 1'b1;
    base  = 19'h00300;
    len   = 19'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("ignored_starts_reads", n_burst_reads, 3);
    chk("ignored_starts_words", n_words, 3);
    chk("ignored_starts_done", n_done - done_before, 1);
    chk("ignored_starts_idle", busy, 0);

    // Reset mid-burst, then a fresh burst.
    done_before = n_done;
    push_burst(19'h00400, 16);
    launch(19'h00400, 19'd16);
    for (int i = 0; i < 50 && n_words < 3; i++) @(negedge clk);
    chk("three_words_seen", n_words >= 3, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs();
    exp_a.delete();
    exp_d.delete();
    exp_l.delete();
    n_issued = 0;
    n_popped = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_done_after_abort", n_done - done_before, 0);
    chk("idle_after_abort", busy, 0);
    push_burst(19'h00600, 2);
    launch(19'h00600, 19'd2);
    wait_done(40, td);
    chk("post_reset_words", n_words, 2);
    chk("post_reset_done_rel", td - t0, 4);
    chk("post_reset_queue_empty", exp_d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
